vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
Arbitrates a single-port synchronous framebuffer RAM between two requesters.
- Display scan-out read path (feeds Module_VGA_Control pixel colour).
- Pixel writer (drawing logic / UART loader), decoupled through a 2-entry write buffer.
- Reads win during active video; buffered writes win during blanking.
- Sits between the VGA timing/colour logic and the block RAM on the Spartan-3E board.

Parameters:
ADDR_W, 15, framebuffer address width (160x120 = 19200 words)
DATA_W, 3, pixel word width (R,G,B bits)
WBUF_DEPTH, 2, write buffer entries (fixed at 2; other values unsupported)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-high; clears all state
iBlank  in  1  1 = horizontal or vertical blanking interval, from the VGA timing logic
iRd_Req  in  1  display read request
iRd_Addr  in  ADDR_W  display read address
oRd_Ready  out  1  read accepted this cycle when iRd_Req=1
oRd_Valid  out  1  oRd_Data valid strobe
oRd_Data  out  DATA_W  read pixel data
iWr_Valid  in  1  writer has a word
iWr_Addr  in  ADDR_W  write address
iWr_Data  in  DATA_W  write data
oWr_Ready  out  1  write buffer can accept
oMem_Addr  out  ADDR_W  RAM address
oMem_WE  out  1  RAM write enable
oMem_WData  out  DATA_W  RAM write data
iMem_RData  in  DATA_W  RAM read data, valid 1 cycle after the address
oWbuf_Count  out  2  write buffer occupancy, 0..2

Behaviour:
- Reset values: all outputs 0; write buffer empty; read pipeline cleared.
- Per-cycle grant is combinational from current inputs and buffer state:
  - Active video (iBlank=0): read has priority.
    - If iRd_Req=1: read granted, oRd_Ready=1, oMem_WE=0, oMem_Addr=iRd_Addr.
    - Else, if the buffer is non-empty: write granted from the buffer head.
  - Blanking (iBlank=1), buffer non-empty: write granted, oRd_Ready=0; any read is refused and must be held by the requester.
  - Blanking, buffer empty: read granted if requested.
  - No grant: oMem_WE=0; oMem_Addr holds its previous value.
- Read pipeline:
  - Accepted read at cycle N → RAM data at N+1 → oRd_Data registered at N+2 with oRd_Valid=1 for exactly one cycle.
  - Back-to-back reads give one result per cycle, in order.
- Write buffer: 2-entry FIFO.
  - Push when iWr_Valid & oWr_Ready; oWr_Ready = (count<2).
  - Pop on write grant: oMem_WE=1, oMem_WData/oMem_Addr = head entry. Entries are written to RAM in push order.
  - Push and pop in the same cycle: count unchanged.
  - No pass-through: a word pushed at cycle N is eligible for the RAM no earlier than N+1.
  - Full (count=2): oWr_Ready=0; an incoming word is not consumed, and the writer holds it.
  - Full with a pop in the same cycle: oWr_Ready still 0 (registered-count based), and the word is not accepted that cycle.
- Buffer pointers are 1 bit and wrap modulo 2.
- Read-after-write to the same address: no forwarding; the read returns RAM content at grant time.
- Reset mid-operation: buffered writes are discarded and an in-flight oRd_Valid is suppressed. The first cycle after deassertion behaves as a fresh start.

Optional Feature:
Macro VGA_FB_ARB_STATS_EN.
- Defined: adds outputs
  - oStall_Cycles (16 bits): increments on each cycle with iWr_Valid=1 and oWr_Ready=0; saturates at 0xFFFF.
  - oRd_Refused (16 bits): increments on each cycle with iRd_Req=1 and oRd_Ready=0; saturates at 0xFFFF.
  - Both counters are cleared by Reset.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset held 3 cycles, then released, with iBlank=0 and no requests → all outputs 0 and oWbuf_Count=0 throughout.
2. iBlank=0, reads at addresses 0x0010,0x0011,0x0012 on consecutive cycles; RAM model returns addr[2:0] → oRd_Valid on cycles N+2..N+4 with data 0,1,2 in order.
3. iBlank=0, continuous iRd_Req; writer pushes (0x0100,5),(0x0101,6),(0x0102,7) → first two accepted, third held with oWr_Ready=0, oWbuf_Count=2, oMem_WE never 1. Then iBlank=1 → RAM writes 5 to 0x0100 and 6 to 0x0101 on two consecutive cycles, third word accepted afterwards, oRd_Ready=0 while the buffer is non-empty.
4. iBlank=1, buffer empty, iRd_Req=1 at 0x0200 → read granted; oRd_Valid 2 cycles later.
5. iBlank=0, no reads; one push per cycle for 4 cycles → each word written on the cycle after its push, oWbuf_Count ≤ 1, addresses in push order.
6. Buffer holding 2 entries with a read in flight; assert Reset for 1 cycle → no oMem_WE afterwards, no oRd_Valid, oWbuf_Count=0. With STATS_EN defined, the counters read 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer RAM arbiter between display reads and a 2-entry write buffer.
// Reads win during active video, buffered writes win during blanking.
// Optional VGA_FB_ARB_STATS_EN adds saturating stall / refused-read counters.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 3,
  parameter int WBUF_DEPTH = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iBlank,
  input  logic              iRd_Req,
  input  logic [ADDR_W-1:0] iRd_Addr,
  output logic              oRd_Ready,
  output logic              oRd_Valid,
  output logic [DATA_W-1:0] oRd_Data,
  input  logic              iWr_Valid,
  input  logic [ADDR_W-1:0] iWr_Addr,
  input  logic [DATA_W-1:0] iWr_Data,
  output logic              oWr_Ready,
  output logic [ADDR_W-1:0] oMem_Addr,
  output logic              oMem_WE,
  output logic [DATA_W-1:0] oMem_WData,
  input  logic [DATA_W-1:0] iMem_RData,
  output logic [1:0]        oWbuf_Count
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0]       oStall_Cycles,
  output logic [15:0]       oRd_Refused
`endif
);
  localparam logic [1:0] DEPTH = WBUF_DEPTH[1:0];
  logic [ADDR_W-1:0] bufAddr [2];
  logic [DATA_W-1:0] bufData [2];
  logic              wrPtr, rdPtr, rdPending, hasWord, rdGrant, wrGrant, push;
  logic [ADDR_W-1:0] addrHold;
  // Grant selection: reads first in active video, buffered writes first in blanking
  always_comb begin
    hasWord    = oWbuf_Count != 2'd0;
    rdGrant    = ~Reset & iRd_Req & (~iBlank | ~hasWord);
    wrGrant    = ~Reset & hasWord & ~rdGrant;
    oWr_Ready  = ~Reset & (oWbuf_Count < DEPTH);
    push       = iWr_Valid & oWr_Ready;
    oRd_Ready  = rdGrant;
    oMem_WE    = wrGrant;
    oMem_WData = wrGrant ? bufData[rdPtr] : '0;
    oMem_Addr  = rdGrant ? iRd_Addr : wrGrant ? bufAddr[rdPtr] : addrHold;
  end
  // Write FIFO: occupancy tracks push minus pop, pointers wrap modulo 2
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bufAddr     <= '{default: '0};
      bufData     <= '{default: '0};
      wrPtr       <= 1'b0;
      rdPtr       <= 1'b0;
      oWbuf_Count <= 2'd0;
    end else begin
      if (push) begin
        bufAddr[wrPtr] <= iWr_Addr;
        bufData[wrPtr] <= iWr_Data;
        wrPtr          <= ~wrPtr;
      end
      if (wrGrant) rdPtr <= ~rdPtr;
      oWbuf_Count <= oWbuf_Count + {1'b0, push} - {1'b0, wrGrant};
    end
  end
  // Read pipeline: grant, RAM latency, output register; address held when idle
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdPending <= 1'b0;
      oRd_Valid <= 1'b0;
      oRd_Data  <= '0;
      addrHold  <= '0;
    end else begin
      rdPending <= rdGrant;
      oRd_Valid <= rdPending;
      if (rdPending) oRd_Data <= iMem_RData;
      addrHold  <= oMem_Addr;
    end
  end
`ifdef VGA_FB_ARB_STATS_EN
  // Saturating counters for writer stalls and refused display reads
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oStall_Cycles <= '0;
      oRd_Refused   <= '0;
    end else begin
      if (iWr_Valid & ~oWr_Ready & ~&oStall_Cycles) oStall_Cycles <= oStall_Cycles + 16'd1;
      if (iRd_Req & ~oRd_Ready & ~&oRd_Refused) oRd_Refused <= oRd_Refused + 16'd1;
    end
  end
`endif
endmodule
